// File: rtl/mesh_term_sink_if.sv
// Router-output handshake between a mesh_gnrtr external port and its terminal sink.
// The router side drives the head packet; the sink answers with a one-cycle pop.
interface mesh_term_sink_if #(
  parameter int pckg_sz = 40
);
  logic               pndng;
  logic [pckg_sz-1:0] data_out;
  logic               pop;

  modport master (output pndng, output data_out, input  pop);
  modport slave  (input  pndng, input  data_out, output pop);
endinterface

// File: rtl/mesh_term_sink.sv
// Terminal endpoint for one mesh_gnrtr port: pops router packets into a local
// first-word-fall-through FIFO, checks destination against its ID, keeps statistics.
module mesh_term_sink #(
  parameter int pckg_sz = 40,
  parameter int DEPTH   = 8,
  parameter int ID_ROW  = 0,
  parameter int ID_COL  = 0,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  mesh_term_sink_if.slave            rtr,
  input  logic                       rd_en,
  output logic [pckg_sz-1:0]         rd_data,
  output logic                       rx_empty,
  output logic [$clog2(DEPTH+1)-1:0] rx_count,
  output logic [CNT_W-1:0]           pkt_cnt,
  output logic [CNT_W-1:0]           misroute_cnt,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic                       misroute
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [3:0] ROW = ID_ROW[3:0];
  localparam logic [3:0] COL = ID_COL[3:0];

  typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;

  state_t             state, state_nxt;
  logic               accept, stall, do_rd, full, dest_ok, pop_q;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [pckg_sz-1:0] mem [DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign rx_empty = (count == '0);
  assign rx_count = count;
  assign rd_data  = mem[rd_ptr];
  assign do_rd    = rd_en && !rx_empty;
  assign rtr.pop  = pop_q;
  assign dest_ok  = (rtr.data_out[pckg_sz-9  -: 4] == ROW) &&
                    (rtr.data_out[pckg_sz-13 -: 4] == COL);

  // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (rtr.pndng) begin
          if (!full) begin
            accept    = 1'b1;
            state_nxt = POP;
          end else begin
            stall = 1'b1;
          end
        end
      end
      POP:     state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pop_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pop_q <= accept;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd)  rd_ptr <= rd_ptr + AW'(1);
      case ({accept, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the cleared pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (accept && !reset) mem[wr_ptr] <= rtr.data_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt      <= '0;
      misroute_cnt <= '0;
      stall_cnt    <= '0;
      misroute     <= 1'b0;
    end else begin
      if (accept) pkt_cnt <= sat_inc(pkt_cnt);
      if (accept && !dest_ok) begin
        misroute_cnt <= sat_inc(misroute_cnt);
        misroute     <= 1'b1;
      end
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_mesh_term_sink.sv
// Directed bench for mesh_term_sink: cycle table for the basic handshake, then
// sequences for backpressure, pointer wrap with streaming reads, and mid-handshake reset.
module tb_mesh_term_sink;
  localparam int PW    = 40;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  localparam logic [PW-1:0] PA = 40'h0012800ABC;
  localparam logic [PW-1:0] PM = 40'h0030000001;
  localparam logic [PW-1:0] PB = 40'h0012800001;
  localparam logic [PW-1:0] PC = 40'h0012800777;
  localparam logic [PW-1:0] PD = 40'h00128000D0;
  localparam logic [PW-1:0] PE = 40'h00128000E0;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rd_en = 1'b0;
  logic [PW-1:0]    rd_data;
  logic             rx_empty;
  logic [3:0]       rx_count;
  logic [CNT_W-1:0] pkt_cnt, misroute_cnt, stall_cnt;
  logic             misroute;

  logic             auto_rtr = 1'b0;
  logic             tbl_pndng = 1'b0;
  logic [PW-1:0]    tbl_data = '0;
  logic             head_vld = 1'b0;
  logic [PW-1:0]    head_data = '0;
  logic [PW-1:0]    rq[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mesh_term_sink_if #(.pckg_sz(PW)) rtr ();

  assign rtr.pndng    = auto_rtr ? head_vld  : tbl_pndng;
  assign rtr.data_out = auto_rtr ? head_data : tbl_data;

  mesh_term_sink #(
    .pckg_sz(PW), .DEPTH(DEPTH), .ID_ROW(1), .ID_COL(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .rtr(rtr.slave), .rd_en(rd_en), .rd_data(rd_data),
    .rx_empty(rx_empty), .rx_count(rx_count), .pkt_cnt(pkt_cnt),
    .misroute_cnt(misroute_cnt), .stall_cnt(stall_cnt), .misroute(misroute)
  );

  // Router port model: a pop seen in a cycle retires the head, the next packet follows.
  always @(negedge clk) begin
    if (rtr.pop && rq.size() > 0) void'(rq.pop_front());
    head_vld  = (rq.size() > 0);
    head_data = (rq.size() > 0) ? rq[0] : '0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rd_en     = 1'b0;
    tbl_pndng = 1'b0;
    rq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [PW-1:0] good_pkt(input int k);
    return {8'h00, 4'h1, 4'h2, 24'(k)};
  endfunction

  typedef struct {
    logic          pndng;
    logic [PW-1:0] data;
    logic          rd;
    logic          pop;
    logic          empty;
    logic [3:0]    cnt;
    logic [PW-1:0] rdata;
    logic [15:0]   pkt;
    logic [15:0]   mcnt;
    logic          mis;
  } vec_t;

  vec_t tv[17];

  initial begin
    int cyc;
    int pops[$];
    logic [PW-1:0] got[$];
    logic [CNT_W-1:0] s1;
    bit found;
    int viol;

    //        pndng data rd | pop empty cnt rdata pkt mcnt mis
    tv[0]  = '{1'b1, PA, 1'b0, 1'b1, 1'b0, 4'd1, PA, 16'd1, 16'd0, 1'b0};
    tv[1]  = '{1'b1, PA, 1'b0, 1'b0, 1'b0, 4'd1, PA, 16'd1, 16'd0, 1'b0};
    tv[2]  = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd1, PA, 16'd1, 16'd0, 1'b0};
    tv[3]  = '{1'b1, PM, 1'b0, 1'b1, 1'b0, 4'd2, PA, 16'd2, 16'd1, 1'b1};
    tv[4]  = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd2, PA, 16'd2, 16'd1, 1'b1};
    tv[5]  = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd1, PM, 16'd2, 16'd1, 1'b1};
    tv[6]  = '{1'b1, PB, 1'b0, 1'b1, 1'b0, 4'd2, PM, 16'd3, 16'd1, 1'b1};
    tv[7]  = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd1, PB, 16'd3, 16'd1, 1'b1};
    tv[8]  = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 4'd0, '0, 16'd3, 16'd1, 1'b1};
    tv[9]  = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 4'd0, '0, 16'd3, 16'd1, 1'b1};
    tv[10] = '{1'b1, PC, 1'b1, 1'b1, 1'b0, 4'd1, PC, 16'd4, 16'd1, 1'b1};
    tv[11] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 4'd0, '0, 16'd4, 16'd1, 1'b1};
    tv[12] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd0, '0, 16'd4, 16'd1, 1'b1};
    tv[13] = '{1'b1, PD, 1'b0, 1'b1, 1'b0, 4'd1, PD, 16'd5, 16'd1, 1'b1};
    tv[14] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd1, PD, 16'd5, 16'd1, 1'b1};
    tv[15] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd1, PD, 16'd5, 16'd1, 1'b1};
    tv[16] = '{1'b1, PE, 1'b1, 1'b1, 1'b0, 4'd1, PE, 16'd6, 16'd1, 1'b1};

    do_reset();
    check("rst_pop", rtr.pop, 0);
    check("rst_empty", rx_empty, 1);
    check("rst_count", rx_count, 0);
    check("rst_pkt", pkt_cnt, 0);
    check("rst_mis", misroute, 0);

    // Cycle table: inputs applied at a falling edge, outputs checked one edge later.
    for (int i = 0; i < 17; i++) begin
      tbl_pndng = tv[i].pndng;
      tbl_data  = tv[i].data;
      rd_en     = tv[i].rd;
      @(negedge clk);
      check($sformatf("v%0d_pop", i), rtr.pop, tv[i].pop);
      check($sformatf("v%0d_empty", i), rx_empty, tv[i].empty);
      check($sformatf("v%0d_count", i), rx_count, tv[i].cnt);
      if (!tv[i].empty) check($sformatf("v%0d_rdata", i), rd_data, tv[i].rdata);
      check($sformatf("v%0d_pkt", i), pkt_cnt, tv[i].pkt);
      check($sformatf("v%0d_mcnt", i), misroute_cnt, tv[i].mcnt);
      check($sformatf("v%0d_mis", i), misroute, tv[i].mis);
    end
    tbl_pndng = 1'b0;
    rd_en     = 1'b0;
    check("tbl_stall", stall_cnt, 0);

    // Backpressure: ten packets offered, only eight fit.
    do_reset();
    auto_rtr = 1'b1;
    for (int k = 0; k < 10; k++) rq.push_back(good_pkt(k));
    cyc = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      cyc++;
      if (rtr.pop) pops.push_back(cyc);
    end
    check("bp_pops", pops.size(), 8);
    for (int k = 1; k < pops.size(); k++)
      check($sformatf("bp_gap%0d", k), pops[k] - pops[k-1], 3);
    check("bp_count", rx_count, 8);
    s1 = stall_cnt;
    check("bp_stall_nz", (s1 > 0), 1);
    repeat (4) @(negedge clk);
    check("bp_stall_inc", stall_cnt, s1 + 4);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 3 && !found; j++) begin
      if (rtr.pop) found = 1'b1;
      else @(negedge clk);
    end
    check("bp_resume", found, 1);
    check("bp_head", rd_data, good_pkt(1));
    check("bp_refill", rx_count, 8);

    // Streaming: read whenever non-empty; 20 packets wrap an 8-deep FIFO twice.
    do_reset();
    for (int k = 0; k < 20; k++) rq.push_back(good_pkt(100 + k));
    viol = 0;
    for (int n = 0; n < 200 && got.size() < 20; n++) begin
      if (rx_count > 1) viol++;
      if (!rx_empty) begin
        got.push_back(rd_data);
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
      @(negedge clk);
    end
    rd_en = 1'b0;
    check("wr_got", got.size(), 20);
    for (int k = 0; k < got.size(); k++)
      check($sformatf("wr_order%0d", k), got[k], good_pkt(100 + k));
    check("wr_maxcnt", viol, 0);
    check("wr_pkt", pkt_cnt, 20);

    // Reset while the third pop is on the wire.
    do_reset();
    rq.push_back(good_pkt(200));
    rq.push_back(PM);
    rq.push_back(good_pkt(201));
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (rtr.pop && rx_count == 3) found = 1'b1;
    end
    check("mr_reach", found, 1);
    check("mr_mis_pre", misroute, 1);
    reset = 1'b1;
    rq.delete();
    @(negedge clk);
    check("mr_pop", rtr.pop, 0);
    check("mr_empty", rx_empty, 1);
    check("mr_count", rx_count, 0);
    check("mr_pkt", pkt_cnt, 0);
    check("mr_mcnt", misroute_cnt, 0);
    check("mr_stall", stall_cnt, 0);
    check("mr_mis", misroute, 0);
    reset = 1'b0;
    rq.push_back(good_pkt(300));
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (rtr.pop) found = 1'b1;
    end
    check("mr_resume", found, 1);
    check("mr_rdata", rd_data, good_pkt(300));
    check("mr_count1", rx_count, 1);
    check("mr_pkt1", pkt_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mesh_term_sink.md
Name: mesh_term_sink

Overview:
- Synthesizable terminal endpoint that attaches to one external port of mesh_gnrtr.
- Plays the consumer role on the router output side: watches pndng/data_out, issues pop, and checks each packet's destination against its own terminal ID.
- Buffers accepted packets in a local FWFT FIFO and keeps receive statistics.
- Replaces the bench monitor as a hardware sink for system-level builds.

Parameters:
- pckg_sz, 40, packet width in bits.
- DEPTH, 8, local receive FIFO depth in entries; power of 2, minimum 2.
- ID_ROW, 0, terminal row ID, 4 bits.
- ID_COL, 0, terminal column ID, 4 bits.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pndng  in  1  router port has a packet at its head.
- data_out  in  pckg_sz  router head packet; valid while pndng=1.
- pop  out  1  one-cycle pulse that removes the router head.
- rd_en  in  1  consumer read strobe.
- rd_data  out  pckg_sz  local FIFO head (first-word-fall-through).
- rx_empty  out  1  local FIFO empty.
- rx_count  out  $clog2(DEPTH+1)  local FIFO occupancy.
- pkt_cnt  out  CNT_W  packets accepted.
- misroute_cnt  out  CNT_W  accepted packets whose destination does not match this terminal.
- stall_cnt  out  CNT_W  cycles in IDLE with pndng=1 and local FIFO full.
- misroute  out  1  sticky: at least one misroute seen since reset.

Behaviour:
- Packet fields:
  - [pckg_sz-1:pckg_sz-8] next-jump.
  - [pckg_sz-9:pckg_sz-12] target row.
  - [pckg_sz-13:pckg_sz-16] target column.
  - [pckg_sz-17] mode.
  - Remaining bits: payload.
- Reset, synchronous, checked every edge:
  - pop=0, state=IDLE.
  - FIFO pointers cleared; rx_empty=1, rx_count=0.
  - All counters 0; misroute=0.
  - rd_data is don't-care while empty.
  - Reset mid-handshake aborts it: pop is 0 on the cycle after reset is sampled, and no partial write is kept.
- FSM IDLE -> POP -> WAIT -> IDLE.
  - IDLE, pndng=1 and rx_count<DEPTH:
    - At the edge, write data_out into the FIFO.
    - Register pop<=1.
    - pkt_cnt+=1.
    - misroute_cnt+=1 and misroute<=1 if target row != ID_ROW or target column != ID_COL.
    - Go to POP.
  - IDLE, pndng=1 and FIFO full: stall_cnt+=1, stay in IDLE, pop=0.
  - IDLE, pndng=0: stay in IDLE.
  - POP: pop=1 for exactly this cycle; go to WAIT.
  - WAIT: pop=0; the router head settles; go to IDLE.
- Throughput and latency:
  - Maximum rate is 1 packet per 3 cycles.
  - pop rises 1 cycle after pndng is first sampled high in IDLE.
  - Packet is visible on rd_data and rx_empty=0 in the pop cycle.
- pop is never high for 2 consecutive cycles.
- pop is never asserted when the FIFO was full at the decision edge.
- Read side:
  - rd_en with rx_empty=1 is ignored; no pointer or count change.
  - rd_en with rx_empty=0 advances the head at the edge.
  - Write and read on the same edge: rx_count unchanged, order preserved.
  - A read on the same edge as a full-state stall frees a slot; the next IDLE cycle may pop.
- Pointers wrap modulo DEPTH; rx_count is the exact occupancy, 0..DEPTH.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- No data loss: every popped packet is stored; the FIFO cannot overflow.

Test Plan:
- Single correct packet (ID_ROW=1, ID_COL=2), pndng=1 with data_out=40'h0012800ABC held until pop:
  - pop pulses 1 cycle, 1 cycle after pndng is sampled.
  - rd_data=40'h0012800ABC, rx_count=1, pkt_cnt=1, misroute=0.
- Misrouted packet 40'h0030000001:
  - Packet is stored.
  - misroute_cnt=1, misroute=1 and stays 1 after subsequent correct packets.
- Backpressure (DEPTH=8), pndng held high with distinct packets, rd_en=0:
  - Exactly 8 pops spaced 3 cycles apart, then pop stays 0.
  - stall_cnt increments every cycle afterwards.
  - One rd_en resumes a pop within 2 cycles.
- Wrap and simultaneous read/write, 20 packets streamed with rd_en asserted every cycle rx_empty=0:
  - Read-out order equals arrival order.
  - rx_count never exceeds 1.
  - Pointers wrap twice cleanly.
- Reset mid-operation, reset asserted in the POP cycle with FIFO holding 3 entries:
  - Next cycle: pop=0, rx_empty=1, all counters 0.
  - Normal operation resumes the cycle after reset deasserts.
- Empty read, rd_en=1 with rx_empty=1:
  - rx_count stays 0; the next written packet appears intact on rd_data.
